// File: rtl/axi_line_fill_ctrl.sv
// Cache miss engine: optional dirty-victim writeback burst, then a line refill burst, on one AXI4
// master port with a single transaction outstanding at any time.
module axi_line_fill_ctrl #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int LINE_BEATS     = 4,
    parameter int AXI_ID         = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          miss_valid,
    output logic                          miss_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]     miss_addr,
    input  logic                          evict_dirty,
    input  logic [AXI_ADDR_WIDTH-1:0]     evict_addr,
    output logic [$clog2(LINE_BEATS)-1:0] wb_idx,
    input  logic [AXI_DATA_WIDTH-1:0]     wb_data,
    output logic                          fill_we,
    output logic [$clog2(LINE_BEATS)-1:0] fill_idx,
    output logic [AXI_DATA_WIDTH-1:0]     fill_data,
    output logic                          done,
    output logic                          done_err,
    output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic                          M_AXI_AWVALID,
    output logic [AXI_ID_WIDTH-1:0]       M_AXI_AWID,
    output logic [7:0]                    M_AXI_AWLEN,
    output logic [2:0]                    M_AXI_AWSIZE,
    output logic [1:0]                    M_AXI_AWBURST,
    input  logic                          M_AXI_AWREADY,
    output logic [AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                          M_AXI_WLAST,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic [AXI_ID_WIDTH-1:0]       M_AXI_BID,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic                          M_AXI_ARVALID,
    output logic [AXI_ID_WIDTH-1:0]       M_AXI_ARID,
    output logic [7:0]                    M_AXI_ARLEN,
    output logic [2:0]                    M_AXI_ARSIZE,
    output logic [1:0]                    M_AXI_ARBURST,
    input  logic                          M_AXI_ARREADY,
    input  logic [AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic [AXI_ID_WIDTH-1:0]       M_AXI_RID,
    input  logic                          M_AXI_RLAST,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);
    localparam int IW  = $clog2(LINE_BEATS);
    localparam int OFF = $clog2(LINE_BEATS * AXI_DATA_WIDTH / 8);
    localparam logic [IW-1:0]           LAST_IDX = IW'(LINE_BEATS - 1);
    localparam logic [AXI_ID_WIDTH-1:0] ID_C     = AXI_ID_WIDTH'(AXI_ID);

    typedef enum logic [2:0] {IDLE, WB_AW, WB_W, WB_B, RF_AR, RF_R, DONE} state_t;

    state_t                    state_q, state_d;
    logic [IW-1:0]             cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic [AXI_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [AXI_ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;

    // Line-offset bits of the request addresses are deliberately dropped.
    logic unused_offsets;
    assign unused_offsets = ^{miss_addr[OFF-1:0], evict_addr[OFF-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            wb_addr_q <= '0;
            rf_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            wb_addr_q <= wb_addr_d;
            rf_addr_q <= rf_addr_d;
        end
    end

    assign M_AXI_AWADDR  = wb_addr_q;
    assign M_AXI_ARADDR  = rf_addr_q;
    assign M_AXI_AWID    = ID_C;
    assign M_AXI_ARID    = ID_C;
    assign M_AXI_AWLEN   = 8'(LINE_BEATS - 1);
    assign M_AXI_ARLEN   = 8'(LINE_BEATS - 1);
    assign M_AXI_AWSIZE  = 3'($clog2(AXI_DATA_WIDTH / 8));
    assign M_AXI_ARSIZE  = 3'($clog2(AXI_DATA_WIDTH / 8));
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WDATA   = wb_data;
    assign wb_idx        = cnt_q;
    assign fill_idx      = cnt_q;
    assign fill_data     = M_AXI_RDATA;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        wb_addr_d     = wb_addr_q;
        rf_addr_d     = rf_addr_q;
        miss_ready    = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_WLAST   = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        fill_we       = 1'b0;
        done          = 1'b0;
        done_err      = 1'b0;
        case (state_q)
            IDLE: begin
                // Held low while reset is asserted so no request looks accepted.
                miss_ready = !rst;
                if (miss_valid) begin
                    wb_addr_d = {evict_addr[AXI_ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                    rf_addr_d = {miss_addr[AXI_ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                    state_d   = evict_dirty ? WB_AW : RF_AR;
                end
            end
            WB_AW: begin
                M_AXI_AWVALID = 1'b1;
                if (M_AXI_AWREADY) state_d = WB_W;
            end
            WB_W: begin
                M_AXI_WVALID = 1'b1;
                M_AXI_WLAST  = (cnt_q == LAST_IDX);
                if (M_AXI_WREADY) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = WB_B;
                    end
                end
            end
            WB_B: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != 2'b00 || M_AXI_BID != ID_C) err_d = 1'b1;
                    state_d = RF_AR;
                end
            end
            RF_AR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) state_d = RF_R;
            end
            RF_R: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID) begin
                    fill_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (M_AXI_RRESP != 2'b00 || M_AXI_RID != ID_C ||
                        M_AXI_RLAST != (cnt_q == LAST_IDX)) err_d = 1'b1;
                    // Beat count, not RLAST, ends the refill.
                    if (cnt_q == LAST_IDX) state_d = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                done_err = err_q;
                err_d    = 1'b0;
                cnt_d    = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_line_fill_ctrl.sv
// Randomized bench for axi_line_fill_ctrl: a sequential AXI slave plus a line-level reference model
// (expected addresses, beat contents and error outcome per miss).
module tb_axi_line_fill_ctrl;
    localparam int AW = 32, DW = 64, IDW = 4, LB = 4, IW = 2;
    localparam int LINE_BYTES = LB * DW / 8;
    localparam logic [IDW-1:0] TID = '0;

    logic clk = 1'b0, rst = 1'b1;
    logic miss_valid = 0, miss_ready, evict_dirty = 0;
    logic [AW-1:0] miss_addr = '0, evict_addr = '0;
    logic [IW-1:0] wb_idx, fill_idx;
    logic [DW-1:0] wb_data, fill_data;
    logic fill_we, done, done_err;
    logic [AW-1:0] awaddr, araddr;
    logic awvalid, arvalid, wvalid, wlast, bready, rready;
    logic [IDW-1:0] awid, arid;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize;
    logic [1:0] awburst, arburst;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0, rlast = 0;
    logic [1:0] bresp = '0, rresp = '0;
    logic [IDW-1:0] bid = '0, rid = '0;
    logic [DW-1:0] rdata = '0;

    logic [DW-1:0] wbmem [LB];
    assign wb_data = wbmem[wb_idx];

    axi_line_fill_ctrl #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IDW),
                         .LINE_BEATS(LB), .AXI_ID(0)) dut (
        .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_ready(miss_ready),
        .miss_addr(miss_addr), .evict_dirty(evict_dirty), .evict_addr(evict_addr),
        .wb_idx(wb_idx), .wb_data(wb_data), .fill_we(fill_we), .fill_idx(fill_idx),
        .fill_data(fill_data), .done(done), .done_err(done_err),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWID(awid), .M_AXI_AWLEN(awlen),
        .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp), .M_AXI_BID(bid), .M_AXI_BVALID(bvalid),
        .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARID(arid),
        .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst),
        .M_AXI_ARREADY(arready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RID(rid),
        .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic [AW-1:0] maddr, eaddr;
        bit            dirty, bid_bad, chk_lat;
        logic [1:0]    bresp;
        int aw_stall, w_mode, b_dly, ar_stall, r_gap, rresp_beat, rid_beat, rlast_beat, rst_beat;
    } scen_t;

    function automatic scen_t base(input logic [AW-1:0] m);
        scen_t s;
        s.maddr = m; s.eaddr = '0; s.dirty = 0; s.bid_bad = 0; s.chk_lat = 0; s.bresp = 2'b00;
        s.aw_stall = 0; s.w_mode = 0; s.b_dly = 0; s.ar_stall = 0; s.r_gap = 0;
        s.rresp_beat = -1; s.rid_beat = -1; s.rlast_beat = LB - 1; s.rst_beat = -1;
        return s;
    endfunction

    // Everything that must be quiet while reset is held, plus the tied-off burst attributes.
    task automatic chk_quiet(input string tag);
        chk({tag, "_miss_ready"}, 64'(miss_ready), 64'(0));
        chk({tag, "_awvalid"},    64'(awvalid), 64'(0));
        chk({tag, "_wvalid"},     64'(wvalid), 64'(0));
        chk({tag, "_wlast"},      64'(wlast), 64'(0));
        chk({tag, "_bready"},     64'(bready), 64'(0));
        chk({tag, "_arvalid"},    64'(arvalid), 64'(0));
        chk({tag, "_rready"},     64'(rready), 64'(0));
        chk({tag, "_fill_we"},    64'(fill_we), 64'(0));
        chk({tag, "_done"},       64'(done), 64'(0));
        chk({tag, "_done_err"},   64'(done_err), 64'(0));
        chk({tag, "_burst"},      64'({awburst, arburst}), 64'(4'b0101));
        chk({tag, "_len"},        64'({awlen, arlen}), 64'({8'(LB - 1), 8'(LB - 1)}));
        chk({tag, "_wstrb"},      64'(wstrb), 64'({(DW/8){1'b1}}));
    endtask

    task automatic do_miss(input scen_t s);
        logic [AW-1:0] exp_aw, exp_ar;
        logic [DW-1:0] rd;
        bit exp_err;
        int t, st, gap, acc_cyc;
        exp_aw = (s.eaddr / LINE_BYTES) * LINE_BYTES;
        exp_ar = (s.maddr / LINE_BYTES) * LINE_BYTES;
        exp_err = (s.dirty && (s.bresp != 2'b00 || s.bid_bad)) || s.rresp_beat >= 0 ||
                  s.rid_beat >= 0 || s.rlast_beat != LB - 1;
        for (int i = 0; i < LB; i++) wbmem[i] = {$urandom, $urandom};

        miss_valid = 1; miss_addr = s.maddr; evict_dirty = s.dirty; evict_addr = s.eaddr;
        t = 0;
        while (!miss_ready && t < 20) begin @(negedge clk); t++; end
        chk("miss_ready", 64'(miss_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        // Request lines change after accept; the latched copies must be used.
        miss_valid = 0; miss_addr = $urandom; evict_addr = $urandom; evict_dirty = 1'($urandom);

        if (s.dirty) begin
            t = 0;
            while (!awvalid && t < 20) begin @(negedge clk); t++; end
            chk("aw_valid", 64'(awvalid), 64'(1));
            chk("aw_attr", 64'({awlen, awsize, awid}), 64'({8'(LB - 1), 3'd3, TID}));
            for (int k = 0; k <= s.aw_stall; k++) begin
                chk("aw_hold", 64'(awvalid), 64'(1));
                chk("aw_addr", 64'(awaddr), 64'(exp_aw));
                chk("ar_before_aw", 64'(arvalid), 64'(0));
                awready = (k == s.aw_stall);
                @(negedge clk);
            end
            awready = 0;
            for (int b = 0; b < LB; b++) begin
                st = (s.w_mode == 1) ? ((b % 2 == 0) ? 1 : 0) :
                     (s.w_mode == 2) ? int'($urandom_range(2, 0)) : 0;
                t = 0;
                while (!wvalid && t < 20) begin @(negedge clk); t++; end
                for (int k = 0; k <= st; k++) begin
                    wready = (k == st);
                    #1;
                    chk("w_valid", 64'(wvalid), 64'(1));
                    chk("w_data", wdata, wbmem[b]);
                    chk("w_last", 64'(wlast), 64'(b == LB - 1));
                    @(negedge clk);
                end
                wready = 0;
            end
            #1;
            chk("w_count", 64'(wvalid), 64'(0));
            t = 0;
            while (!bready && t < 20) begin @(negedge clk); t++; end
            chk("b_ready", 64'(bready), 64'(1));
            repeat (s.b_dly) begin
                chk("ar_before_b", 64'(arvalid), 64'(0));
                @(negedge clk);
            end
            bvalid = 1; bresp = s.bresp; bid = s.bid_bad ? 4'h5 : TID;
            chk("ar_before_b", 64'(arvalid), 64'(0));
            @(negedge clk);
            bvalid = 0; bresp = 0; bid = 0;
        end

        t = 0;
        while (!arvalid && t < 20) begin @(negedge clk); t++; end
        chk("ar_valid", 64'(arvalid), 64'(1));
        chk("ar_attr", 64'({arlen, arsize, arid}), 64'({8'(LB - 1), 3'd3, TID}));
        for (int k = 0; k <= s.ar_stall; k++) begin
            chk("ar_addr", 64'(araddr), 64'(exp_ar));
            arready = (k == s.ar_stall);
            @(negedge clk);
        end
        arready = 0;

        for (int b = 0; b < LB; b++) begin
            gap = (s.r_gap > 0) ? int'($urandom_range(s.r_gap, 0)) : 0;
            repeat (gap) begin
                rvalid = 0;
                #1;
                chk("r_gap_we", 64'(fill_we), 64'(0));
                chk("r_ready", 64'(rready), 64'(1));
                @(negedge clk);
            end
            rd = {$urandom, $urandom};
            rvalid = 1; rdata = rd;
            rresp = (b == s.rresp_beat) ? 2'b10 : 2'b00;
            rid   = (b == s.rid_beat) ? 4'h3 : TID;
            rlast = (b == s.rlast_beat);
            #1;
            if (b == s.rst_beat) begin
                rst = 1;
                #1;
                chk_quiet("rst_mid");
                rvalid = 0; rlast = 0; rresp = 0; rid = 0;
                @(negedge clk);
                @(negedge clk);
                rst = 0;
                #1;
                chk("rst_release_ready", 64'(miss_ready), 64'(1));
                chk("rst_no_done", 64'(done), 64'(0));
                return;
            end
            chk("r_ready", 64'(rready), 64'(1));
            chk("fill_we", 64'(fill_we), 64'(1));
            chk("fill_idx", 64'(fill_idx), 64'(b));
            chk("fill_data", fill_data, rd);
            @(negedge clk);
        end
        rvalid = 0; rlast = 0; rresp = 0; rid = 0;
        #1;
        chk("done", 64'(done), 64'(1));
        chk("done_err", 64'(done_err), 64'(exp_err));
        if (s.chk_lat) chk("latency", 64'(cyc - acc_cyc + 1), 64'(LB + 2));
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'(0));
        chk("idle_ready", 64'(miss_ready), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        scen_t s;
        #2;
        chk_quiet("reset");
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        chk("reset_release_ready", 64'(miss_ready), 64'(1));

        // Clean miss, zero-wait slave: also checks minimum latency.
        s = base(32'h0000_1238); s.chk_lat = 1;
        do_miss(s);
        // Dirty miss, writeback precedes refill.
        s = base(32'h0000_0100); s.dirty = 1; s.eaddr = 32'h8000_0040;
        do_miss(s);
        // AWREADY stalled 3 cycles, WREADY low every other beat.
        s = base(32'h0001_0008); s.dirty = 1; s.eaddr = 32'h4000_01F7; s.aw_stall = 3; s.w_mode = 1;
        do_miss(s);
        // SLVERR on B: refill still completes, error reported.
        s = base(32'h0000_2000); s.dirty = 1; s.eaddr = 32'h8000_1000; s.bresp = 2'b10;
        do_miss(s);
        // Sticky error must not leak into the next miss.
        s = base(32'h0000_3010);
        do_miss(s);
        // Early RLAST.
        s = base(32'h0000_4000); s.rlast_beat = 1;
        do_miss(s);
        // Bad RID, bad RRESP, bad BID.
        s = base(32'h0000_5000); s.rid_beat = 2;
        do_miss(s);
        s = base(32'h0000_6000); s.rresp_beat = 0;
        do_miss(s);
        s = base(32'h0000_7000); s.dirty = 1; s.eaddr = 32'h9000_0020; s.bid_bad = 1;
        do_miss(s);
        // Reset in the middle of the refill, then a normal miss.
        s = base(32'h0000_8000); s.rst_beat = 2;
        do_miss(s);
        s = base(32'h0000_9028); s.chk_lat = 1;
        do_miss(s);

        for (int n = 0; n < 30; n++) begin
            s = base($urandom);
            s.dirty    = 1'($urandom_range(1, 0));
            s.eaddr    = $urandom;
            s.aw_stall = $urandom_range(3, 0);
            s.w_mode   = 2;
            s.b_dly    = $urandom_range(2, 0);
            s.bresp    = ($urandom_range(4, 0) == 0) ? 2'b10 : 2'b00;
            s.bid_bad  = ($urandom_range(9, 0) == 0);
            s.ar_stall = $urandom_range(2, 0);
            s.r_gap    = 2;
            s.rresp_beat = ($urandom_range(5, 0) == 0) ? int'($urandom_range(LB - 1, 0)) : -1;
            s.rid_beat   = ($urandom_range(7, 0) == 0) ? int'($urandom_range(LB - 1, 0)) : -1;
            s.rlast_beat = ($urandom_range(5, 0) == 0) ? int'($urandom_range(LB, 0)) : LB - 1;
            do_miss(s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
